// File: rtl/p_hit_2_if.sv
// ---------------------------------------------------------------------------
// p_hit_2_if
// Groups the two streaming sides of the p_hit_2 stage:
//   - upstream FWFT FIFO read port (ray numerator/denominator/origin/direction,
//     in_empty, in_rd_en)
//   - downstream FWFT FIFO read port (t, hit point, hit flag, out_rd_en,
//     out_empty, out_full)
// Modports:
//   slave  : view used by p_hit_2 itself
//   master : view used by the logic around it (upstream FIFO + consumer)
// Vector triples are packed [2:0][31:0], index 0 = x, 1 = y, 2 = z.
// ---------------------------------------------------------------------------
interface p_hit_2_if;
    logic signed [31:0] in_num;
    logic signed [31:0] in_den;
    logic [2:0][31:0]   in_origin;
    logic [2:0][31:0]   in_dir;
    logic               in_empty;
    logic               in_rd_en;

    logic signed [31:0] out_t;
    logic [2:0][31:0]   out_p;
    logic               out_hit;
    logic               out_rd_en;
    logic               out_empty;
    logic               out_full;

    modport slave (
        input  in_num, in_den, in_origin, in_dir, in_empty, out_rd_en,
        output in_rd_en, out_t, out_p, out_hit, out_empty, out_full
    );

    modport master (
        output in_num, in_den, in_origin, in_dir, in_empty, out_rd_en,
        input  in_rd_en, out_t, out_p, out_hit, out_empty, out_full
    );
endinterface

// File: rtl/p_hit_2.sv
// ---------------------------------------------------------------------------
// p_hit_2
// Second stage of the ray/plane hit pipeline. Pops one ray from the upstream
// FWFT FIFO, computes t = num/den (signed Q16.16) with a restoring divider
// producing one quotient bit per clock, then the hit point
// P = origin + t*dir, and pushes {t, P, hit} into a small FWFT output FIFO.
// Rays that miss (den==0, t<=0, |t| overflow) still produce one all-zero
// record with hit=0, so output order matches input order one-for-one.
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-low reset
//   bus    - p_hit_2_if.slave: upstream FIFO read side (in_*) and output
//            FIFO read side (out_*)
// ---------------------------------------------------------------------------
module p_hit_2 #(
    parameter int Q_BITS     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clock,
    input  logic     reset,
    p_hit_2_if.slave bus
);
    localparam int DIV_W = 32 + Q_BITS;
    localparam int CNT_W = $clog2(DIV_W + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_F = PTR_W + 1;
    localparam int REC_W = 4 * 32 + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_W - 1);
    localparam logic [CNT_F-1:0] FULL_CNT  = CNT_F'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DIV, MUL, WRITE} state_t;

    state_t             state_q, state_d;
    logic [32:0]        den_mag_q, den_mag_d;
    logic               neg_q, neg_d;
    logic [2:0][31:0]   origin_q, origin_d;
    logic [2:0][31:0]   dir_q, dir_d;
    // Holds the dividend bits still to be consumed (upper part) and the
    // quotient bits already produced (lower part); after DIV_W shifts it is
    // the full quotient.
    logic [DIV_W-1:0]   shift_q, shift_d;
    logic [32:0]        rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        res_t_q, res_t_d;
    logic [2:0][31:0]   res_p_q, res_p_d;
    logic               res_hit_q, res_hit_d;

    logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
    logic [REC_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_F-1:0]   count_q, count_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [33:0]        rem_sh;
    logic               q_bit;
    logic               miss;
    logic [REC_W-1:0]   head;

    // Magnitude of a signed 32-bit value as unsigned 32 bits; 0x80000000
    // maps to 2^31, which still fits.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // Same, widened to 33 bits for the divisor path.
    function automatic logic [32:0] mag33(input logic [31:0] v);
        logic [32:0] ext;
        ext = {v[31], v};
        return v[31] ? (33'd0 - ext) : ext;
    endfunction

    // origin + ((dir * t) >>> Q_BITS), product kept at 64 bits, result and
    // add wrap at 32 bits.
    function automatic logic [31:0] axis_point(input logic [31:0] org,
                                               input logic [31:0] dir,
                                               input logic [31:0] t);
        logic signed [63:0] prod;
        logic signed [63:0] scaled;
        prod   = 64'($signed(dir)) * 64'($signed(t));
        scaled = prod >>> Q_BITS;
        return scaled[31:0] + org;
    endfunction

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = (state_q == WRITE) && !full;
    assign pop   = bus.out_rd_en && !empty;

    // Held low while reset is asserted so nothing is popped during reset.
    assign bus.in_rd_en = reset && (state_q == IDLE) && !bus.in_empty;

    always_comb begin
        state_d   = state_q;
        den_mag_d = den_mag_q;
        neg_d     = neg_q;
        origin_d  = origin_q;
        dir_d     = dir_q;
        shift_d   = shift_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        res_t_d   = res_t_q;
        res_p_d   = res_p_q;
        res_hit_d = res_hit_q;

        rem_sh = {rem_q, shift_q[DIV_W-1]};
        q_bit  = (rem_sh >= {1'b0, den_mag_q});
        // Negative t, zero t and a quotient beyond 31 bits are all misses.
        miss   = neg_q || (|shift_q[DIV_W-1:31]) || (shift_q == '0);

        unique case (state_q)
            IDLE: begin
                if (bus.in_rd_en) begin
                    neg_d     = bus.in_num[31] ^ bus.in_den[31];
                    den_mag_d = mag33(bus.in_den);
                    origin_d  = bus.in_origin;
                    dir_d     = bus.in_dir;
                    shift_d   = {mag32(bus.in_num), {Q_BITS{1'b0}}};
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (bus.in_den == '0) begin
                        res_t_d   = '0;
                        res_p_d   = '0;
                        res_hit_d = 1'b0;
                        state_d   = WRITE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                rem_d   = q_bit ? 33'(rem_sh - {1'b0, den_mag_q}) : rem_sh[32:0];
                shift_d = {shift_q[DIV_W-2:0], q_bit};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                if (miss) begin
                    res_t_d   = '0;
                    res_p_d   = '0;
                    res_hit_d = 1'b0;
                end else begin
                    res_t_d   = shift_q[31:0];
                    res_hit_d = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        res_p_d[i] = axis_point(origin_q[i], dir_q[i], shift_q[31:0]);
                    end
                end
                state_d = WRITE;
            end
            WRITE: begin
                if (!full) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output FIFO: push and pop in the same cycle leave the count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {res_hit_q, res_p_q, res_t_q};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            den_mag_q <= '0;
            neg_q     <= 1'b0;
            origin_q  <= '0;
            dir_q     <= '0;
            shift_q   <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            res_t_q   <= '0;
            res_p_q   <= '0;
            res_hit_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            den_mag_q <= den_mag_d;
            neg_q     <= neg_d;
            origin_q  <= origin_d;
            dir_q     <= dir_d;
            shift_q   <= shift_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            res_t_q   <= res_t_d;
            res_p_q   <= res_p_d;
            res_hit_q <= res_hit_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
        end
    end

    // FWFT head; reads as zero whenever the FIFO holds nothing.
    assign head          = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.out_t     = head[31:0];
    assign bus.out_p     = head[127:32];
    assign bus.out_hit   = head[128];
    assign bus.out_empty = empty;
    assign bus.out_full  = full;
endmodule
